// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, even-parity bit,
// then an idle gap. Feeds the "1011" Moore sequence detector.
module seq_pattern_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                GAP      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_AB  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_LEN = (MAX_AB > GAP) ? MAX_AB : GAP;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [SYNC_W-1:0]   r_sync;
    logic                r_par;
    logic                r_data_ready;
    logic                r_out_bit;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_frame_done;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [SYNC_W-1:0]   w_sync_nxt;
    logic                w_par_nxt;
    logic                w_bit_nxt;
    logic                w_valid_nxt;

    // Next-state logic; r_cnt counts the bits still to follow in the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_sync_nxt  = r_sync;
        w_par_nxt   = r_par;
        w_bit_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_valid && r_data_ready) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = SYNC_LD;
                    w_shift_nxt = data_in;
                    w_par_nxt   = f_even_parity(data_in);
                    w_sync_nxt  = SYNC_PAT << 1;
                    w_bit_nxt   = SYNC_PAT[SYNC_W-1];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SYNC: begin
                w_valid_nxt = 1'b1;
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = DATA_LD;
                    w_bit_nxt   = r_shift[DATA_W-1];
                    w_shift_nxt = r_shift << 1;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_bit_nxt   = r_sync[SYNC_W-1];
                    w_sync_nxt  = r_sync << 1;
                end
            end
            S_DATA: begin
                w_valid_nxt = 1'b1;
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_PARITY;
                    w_bit_nxt   = r_par;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_bit_nxt   = r_shift[DATA_W-1];
                    w_shift_nxt = r_shift << 1;
                end
            end
            S_PARITY: begin
                if (GAP > 0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; ready/busy/done are derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= CNT_ZERO;
            r_shift      <= {DATA_W{1'b0}};
            r_sync       <= {SYNC_W{1'b0}};
            r_par        <= 1'b0;
            r_data_ready <= 1'b0;
            r_out_bit    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_sync       <= w_sync_nxt;
            r_par        <= w_par_nxt;
            r_data_ready <= (w_state_nxt == S_IDLE);
            r_out_bit    <= w_bit_nxt;
            r_out_valid  <= w_valid_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= (w_state_nxt == S_PARITY);
        end
    end

    assign data_ready = r_data_ready;
    assign out_bit    = r_out_bit;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
